// File: rtl/vsq_group_quantizer.sv
// Scales, biases and ReLUs LANES-wide beats into a one-group buffer, then drains the group as symmetric INT8.
// Output starts 23 cycles after the last accepted beat; out_ready stalls hold the beat, and in_ready stays low until the group has drained.
module vsq_group_quantizer #(
    parameter int LANES = 16,
    parameter int IN_W  = 24,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           cfg_scale,
    input  logic [15:0]           cfg_bias,
    input  logic                  cfg_relu_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IN_W-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*8-1:0]    out_data,
    output logic                  out_last,
    output logic [15:0]           out_amax,
    output logic                  busy
);
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = AW + 1;
    localparam int DIV_ITERS = 23;
    localparam logic [22:0] DIVIDEND = 23'(127 << 16);

    typedef enum logic [1:0] {S_FILL, S_DIV, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]       grp_len_q, grp_len_d;
    logic [CW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [15:0]         amax_q, amax_d;
    logic [22:0]         recip_q, recip_d;
    logic [15:0]         div_rem_q, div_rem_d;
    logic [22:0]         div_quo_q, div_quo_d;
    logic [4:0]          div_cnt_q, div_cnt_d;
    logic [LANES*16-1:0] buf_q [DEPTH];

    logic [LANES*16-1:0] beat_v;
    logic [15:0]         beat_amax;
    logic [15:0]         lane_v;
    logic [LANES*16-1:0] rd_beat;
    logic [16:0]         div_trial;
    logic                div_ge;
    logic [15:0]         div_rem_nxt;
    logic [22:0]         div_quo_nxt;
    logic                in_accept;
    logic                fill_done;
    logic                div_done;
    logic                rd_last;
    logic                out_hs;

    function automatic logic [15:0] front_end(input logic [IN_W-1:0] x,
                                              input logic [15:0]     scale,
                                              input logic [15:0]     bias,
                                              input logic            relu);
        logic signed [40:0] prod;
        logic signed [40:0] b;
        logic [15:0]        v;
        prod = 41'(signed'(x)) * 41'(signed'({1'b0, scale}));
        b    = (prod >>> 8) + 41'(signed'(bias));
        if (relu && b < 0) begin
            b = '0;
        end
        if (b > 41'sd32767) begin
            v = 16'h7FFF;
        end else if (b < -41'sd32768) begin
            v = 16'h8000;
        end else begin
            v = b[15:0];
        end
        return v;
    endfunction

    // -32768 folds onto 32767 so the magnitude always fits the positive range.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        logic [15:0] a;
        if (v == 16'h8000) begin
            a = 16'h7FFF;
        end else if (v[15]) begin
            a = -v;
        end else begin
            a = v;
        end
        return a;
    endfunction

    function automatic logic [7:0] quant(input logic [15:0] v, input logic [22:0] recip);
        logic signed [40:0] t;
        logic signed [40:0] q;
        logic [7:0]         r;
        t = 41'(signed'(v)) * 41'(signed'({1'b0, recip})) + 41'sd32768;
        q = t >>> 16;
        if (q > 41'sd127) begin
            r = 8'h7F;
        end else if (q < -41'sd127) begin
            r = 8'h81;
        end else begin
            r = q[7:0];
        end
        return r;
    endfunction

    assign in_accept = in_valid && (state_q == S_FILL);
    assign fill_done = in_accept && (in_last || (wr_cnt_q == CW'(DEPTH - 1)));
    assign div_done  = (state_q == S_DIV) && (div_cnt_q == 5'(DIV_ITERS - 1));
    assign rd_last   = (rd_ptr_q == grp_len_q - CW'(1));
    assign out_hs    = out_ready && (state_q == S_DRAIN);

    always_comb begin
        beat_v    = '0;
        beat_amax = '0;
        lane_v    = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_v = front_end(in_data[i*IN_W +: IN_W], cfg_scale, cfg_bias, cfg_relu_en);
            beat_v[i*16 +: 16] = lane_v;
            if (abs16(lane_v) > beat_amax) begin
                beat_amax = abs16(lane_v);
            end
        end
    end

    // Restoring divider step: shift in the next dividend bit, subtract if it fits.
    assign div_trial   = {div_rem_q, div_quo_q[22]};
    assign div_ge      = div_trial >= {1'b0, amax_q};
    assign div_rem_nxt = div_ge ? 16'(div_trial - {1'b0, amax_q}) : div_trial[15:0];
    assign div_quo_nxt = {div_quo_q[21:0], div_ge};

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_FILL: begin
                in_ready = 1'b1;
                if (fill_done) begin
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (div_done) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && rd_last) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        grp_len_d = grp_len_q;
        rd_ptr_d  = rd_ptr_q;
        amax_d    = amax_q;
        recip_d   = recip_q;
        div_rem_d = div_rem_q;
        div_quo_d = div_quo_q;
        div_cnt_d = div_cnt_q;
        if (in_accept) begin
            wr_cnt_d = wr_cnt_q + CW'(1);
            if (beat_amax > amax_q) begin
                amax_d = beat_amax;
            end
            if (fill_done) begin
                grp_len_d = wr_cnt_q + CW'(1);
                div_rem_d = '0;
                div_quo_d = DIVIDEND;
                div_cnt_d = '0;
            end
        end
        if (state_q == S_DIV) begin
            div_rem_d = div_rem_nxt;
            div_quo_d = div_quo_nxt;
            div_cnt_d = div_cnt_q + 5'd1;
            // A zero group still spends the full divide time; its reciprocal is forced to 0.
            if (div_done) begin
                recip_d  = (amax_q == 16'd0) ? 23'd0 : div_quo_nxt;
                rd_ptr_d = '0;
            end
        end
        if (out_hs) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
            if (rd_last) begin
                wr_cnt_d = '0;
                amax_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            grp_len_q <= '0;
            rd_ptr_q  <= '0;
            amax_q    <= '0;
            recip_q   <= '0;
            div_rem_q <= '0;
            div_quo_q <= '0;
            div_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            grp_len_q <= grp_len_d;
            rd_ptr_q  <= rd_ptr_d;
            amax_q    <= amax_d;
            recip_q   <= recip_d;
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_accept) begin
            buf_q[wr_cnt_q[AW-1:0]] <= beat_v;
        end
    end

    always_comb begin
        rd_beat  = buf_q[rd_ptr_q[AW-1:0]];
        out_data = '0;
        if (state_q == S_DRAIN) begin
            for (int i = 0; i < LANES; i++) begin
                out_data[i*8 +: 8] = quant(rd_beat[i*16 +: 16], recip_q);
            end
        end
    end

    assign out_last = (state_q == S_DRAIN) && rd_last;
    assign out_amax = (state_q == S_DRAIN) ? amax_q : 16'd0;

endmodule

// File: tb/tb_vsq_group_quantizer.sv
// Directed bench for vsq_group_quantizer with a queue-based expected-beat scoreboard.
module tb_vsq_group_quantizer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  cfg_scale = 16'h0100;
    logic [15:0]  cfg_bias = 16'h0000;
    logic         cfg_relu_en = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [383:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         out_last;
    logic [15:0]  out_amax;
    logic         busy;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [15:0]  amax;
    } exp_t;

    exp_t sb_q[$];
    int   stim[16][16];
    int   checks = 0;
    int   errors = 0;

    vsq_group_quantizer dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_scale(cfg_scale), .cfg_bias(cfg_bias), .cfg_relu_en(cfg_relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_amax(out_amax), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int fe(input int x, input logic [15:0] sc, input logic [15:0] bias, input bit relu);
        longint p, b;
        p = (longint'(x) * longint'(sc)) >>> 8;
        b = p + longint'($signed(bias));
        if (relu && b < 0) b = 0;
        if (b > 32767) return 32767;
        if (b < -32768) return -32768;
        return int'(b);
    endfunction

    function automatic int qz(input int v, input int recip);
        longint t;
        t = (longint'(v) * longint'(recip) + 32768) >>> 16;
        if (t > 127) return 127;
        if (t < -127) return -127;
        return int'(t);
    endfunction

    task automatic clear_stim();
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 16; i++)
                stim[b][i] = 0;
    endtask

    // Drives n beats and pushes the model's expected output beats.
    task automatic feed(input int n, input bit use_last);
        int vb[16][16];
        int amax;
        int recip;
        exp_t e;
        amax = 0;
        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 16; i++) begin
                int x;
                int a;
                x = stim[b][i];
                in_data[i*24 +: 24] = x[23:0];
                vb[b][i] = fe(x, cfg_scale, cfg_bias, cfg_relu_en);
                a = (vb[b][i] < 0) ? -vb[b][i] : vb[b][i];
                if (a > 32767) a = 32767;
                if (a > amax) amax = a;
            end
            in_valid = 1'b1;
            in_last  = use_last && (b == n - 1);
            check("in_ready_fill", in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        recip = (amax == 0) ? 0 : (127 * 65536) / amax;
        for (int b = 0; b < n; b++) begin
            e = '0;
            for (int i = 0; i < 16; i++) begin
                int q;
                q = qz(vb[b][i], recip);
                e.data[i*8 +: 8] = q[7:0];
            end
            e.last = (b == n - 1);
            e.amax = amax[15:0];
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_out(input bit garbage);
        int k;
        k = 0;
        if (garbage) begin
            in_valid = 1'b1;
            in_last  = 1'b1;
            in_data  = {12{32'h5A5A_A5A5}};
        end
        while (!out_valid && k < 40) begin
            check("in_ready_div", in_ready, 1'b0);
            check("busy_div", busy, 1'b1);
            @(posedge clk); #1;
            k++;
        end
        check("div_latency", k, 23);
    endtask

    task automatic drain(input int stall_at, input int stall_len, input int stop_after);
        int idx;
        exp_t e;
        idx = 0;
        while (sb_q.size() > 0) begin
            if (idx == stop_after) return;
            e = sb_q.pop_front();
            check("out_valid", out_valid, 1'b1);
            if (!out_valid) begin
                sb_q.delete();
                break;
            end
            if (idx == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_data", out_data, e.data);
                    check("stall_last", out_last, e.last);
                    check("stall_in_ready", in_ready, 1'b0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
            check("out_amax", out_amax, e.amax);
            check("in_ready_drain", in_ready, 1'b0);
            @(posedge clk); #1;
            idx++;
        end
        check("end_out_valid", out_valid, 1'b0);
        check("end_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_amax", out_amax, 16'd0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Signed quantization, 16 beats with implicit last.
        clear_stim();
        for (int b = 0; b < 16; b++) begin
            stim[b][0] = 1000; stim[b][1] = 500; stim[b][2] = -1000;
        end
        cfg_scale = 16'h0100; cfg_bias = 16'h0000; cfg_relu_en = 1'b0;
        feed(16, 1'b0);
        wait_out(1'b0);
        check("t1_amax", out_amax, 16'd1000);
        check("t1_lane0", out_data[7:0], 8'h7F);
        check("t1_lane1", out_data[15:8], 8'h3F);
        check("t1_lane2", out_data[23:16], 8'h81);
        drain(-1, 0, -1);

        // ReLU and negative bias, single-beat group.
        clear_stim();
        stim[0][0] = 10; stim[0][1] = 100;
        cfg_relu_en = 1'b1; cfg_bias = 16'hFFF0;
        feed(1, 1'b1);
        wait_out(1'b0);
        check("t2_amax", out_amax, 16'd84);
        check("t2_lane1", out_data[15:8], 8'h7F);
        drain(-1, 0, -1);

        // Saturation at both rails.
        clear_stim();
        stim[0][0] = 1 << 20; stim[0][1] = -(1 << 20);
        cfg_relu_en = 1'b0; cfg_bias = 16'h0000; cfg_scale = 16'h1000;
        feed(1, 1'b1);
        wait_out(1'b0);
        check("t3_amax", out_amax, 16'd32767);
        drain(-1, 0, -1);

        // All-zero group of three beats.
        clear_stim();
        cfg_scale = 16'h0100;
        feed(3, 1'b1);
        wait_out(1'b0);
        drain(-1, 0, -1);

        // Backpressure mid-drain with input pressure during DIV and DRAIN.
        clear_stim();
        for (int b = 0; b < 6; b++) begin
            stim[b][0] = (b + 1) * 300;
            stim[b][1] = -(b * 200);
            stim[b][5] = b * 77 - 100;
        end
        feed(6, 1'b1);
        wait_out(1'b1);
        drain(2, 5, -1);

        // Reset while the fifth beat is on the output.
        clear_stim();
        for (int b = 0; b < 8; b++) begin
            stim[b][0] = 30000 - b * 1000;
            stim[b][3] = -b * 500;
        end
        feed(8, 1'b1);
        wait_out(1'b0);
        drain(-1, 0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        sb_q.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        clear_stim();
        stim[0][0] = 50; stim[0][1] = -25;
        stim[1][0] = 20; stim[1][2] = -50;
        feed(2, 1'b1);
        wait_out(1'b0);
        check("t6_amax", out_amax, 16'd50);
        drain(-1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
